// File: rtl/brush_painter.sv
// brush_painter: rasters the clipped bounding box of a circular brush and issues one
// grid-memory write request per cell lying inside the circle.
`timescale 1ns/1ps
`default_nettype none

module brush_painter #(
    parameter int GRID_W  = 160,
    parameter int GRID_H  = 120,
    parameter int COORD_W = 8,
    parameter int TYPE_W  = 2,
    parameter int ADDR_W  = 15
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [COORD_W-1:0] brush_x_i,
    input  logic [COORD_W-1:0] brush_y_i,
    input  logic [COORD_W-1:0] brush_r_i,
    input  logic [TYPE_W-1:0]  brush_t_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [TYPE_W-1:0]  mem_data_o
);

    localparam int SW = COORD_W + 2;
    localparam int QW = 2 * COORD_W;
    localparam logic [SW-1:0] c_XMAX = SW'(GRID_W - 1);
    localparam logic [SW-1:0] c_YMAX = SW'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [COORD_W-1:0]   x_q, y_q, r_q;
    logic [COORD_W-1:0]   x0_q, x1_q, y1_q;
    logic [COORD_W-1:0]   cx_q, cy_q;
    logic                 busy_q, done_q, req_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [TYPE_W-1:0]    data_q;

    logic [COORD_W-1:0]   x0_d, x1_d, y0_d, y1_d;
    logic [SW-1:0]        sx1_d, sy1_d;
    logic                 offgrid_d;
    logic [COORD_W-1:0]   cx_d, cy_d;
    logic [COORD_W-1:0]   adx_d, ady_d;
    logic [QW-1:0]        dx2_d, dy2_d, r2_d;
    logic [QW:0]          dist_d;
    logic                 in_d;
    logic [ADDR_W-1:0]    addr_d;

    // Bounding box clip and the next cursor position; the inside test and address are
    // evaluated for the cell about to be presented so the outputs can be registered.
    always_comb begin
        x0_d      = (x_q >= r_q) ? (x_q - r_q) : '0;
        y0_d      = (y_q >= r_q) ? (y_q - r_q) : '0;
        sx1_d     = {2'b00, x_q} + {2'b00, r_q};
        sy1_d     = {2'b00, y_q} + {2'b00, r_q};
        x1_d      = (sx1_d > c_XMAX) ? c_XMAX[COORD_W-1:0] : sx1_d[COORD_W-1:0];
        y1_d      = (sy1_d > c_YMAX) ? c_YMAX[COORD_W-1:0] : sy1_d[COORD_W-1:0];
        offgrid_d = ({2'b00, x_q} > c_XMAX) || ({2'b00, y_q} > c_YMAX);

        if (state_q == S_SETUP) begin
            cx_d = x0_d;
            cy_d = y0_d;
        end else if (cx_q == x1_q) begin
            cx_d = x0_q;
            cy_d = cy_q + 1'b1;
        end else begin
            cx_d = cx_q + 1'b1;
            cy_d = cy_q;
        end

        adx_d  = (cx_d >= x_q) ? (cx_d - x_q) : (x_q - cx_d);
        ady_d  = (cy_d >= y_q) ? (cy_d - y_q) : (y_q - cy_d);
        dx2_d  = adx_d * adx_d;
        dy2_d  = ady_d * ady_d;
        r2_d   = r_q * r_q;
        dist_d = {1'b0, dx2_d} + {1'b0, dy2_d};
        in_d   = (dist_d <= {1'b0, r2_d});
        addr_d = ADDR_W'(cy_d) * ADDR_W'(GRID_W) + ADDR_W'(cx_d);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        x_q     <= brush_x_i;
                        y_q     <= brush_y_i;
                        r_q     <= brush_r_i;
                        data_q  <= brush_t_i;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (offgrid_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        x0_q    <= x0_d;
                        x1_q    <= x1_d;
                        y1_q    <= y1_d;
                        cx_q    <= cx_d;
                        cy_q    <= cy_d;
                        req_q   <= in_d;
                        addr_q  <= addr_d;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A pending request holds everything until the arbiter grants it.
                    if (!req_q || mem_gnt_i) begin
                        if (cx_q == x1_q && cy_q == y1_q) begin
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cx_q   <= cx_d;
                            cy_q   <= cy_d;
                            req_q  <= in_d;
                            addr_q <= addr_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_brush_painter.sv
// tb_brush_painter: drives brush strokes and compares writes and handshake timing
// against a per-cell circle model of the grid.
`timescale 1ns/1ps
`default_nettype none

module tb_brush_painter;

    localparam int GW = 160;
    localparam int GH = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bx, by, br;
    logic [1:0]  bt;
    logic        busy, done, req, gnt;
    logic [14:0] addr;
    logic [1:0]  data;

    int total = 0;
    int bad   = 0;

    brush_painter #(
        .GRID_W (GW),
        .GRID_H (GH),
        .COORD_W(8),
        .TYPE_W (2),
        .ADDR_W (15)
    ) dut (
        .clock_i   (clk),
        .reset_i   (rst),
        .start_i   (start),
        .brush_x_i (bx),
        .brush_y_i (by),
        .brush_r_i (br),
        .brush_t_i (bt),
        .busy_o    (busy),
        .done_o    (done),
        .mem_req_o (req),
        .mem_gnt_i (gnt),
        .mem_addr_o(addr),
        .mem_data_o(data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // gmode: 0 grant always high, 1 random grant, 2 grant withheld for the first 3 request cycles
    task automatic run_stroke(input int x, input int y, input int r, input int t,
                              input int gmode, input int restart_at, input int reset_at);
        int   exp_addr[$];
        int   exp_cyc[$];
        int   idx, done_k, holds;
        bit   finished;
        logic prev_req, prev_gnt;
        logic [14:0] prev_addr;

        idx = 0;
        if (x < GW && y < GH) begin
            int x0, x1, y0, y1;
            x0 = (x - r < 0) ? 0 : x - r;
            y0 = (y - r < 0) ? 0 : y - r;
            x1 = (x + r > GW - 1) ? GW - 1 : x + r;
            y1 = (y + r > GH - 1) ? GH - 1 : y + r;
            for (int cy = y0; cy <= y1; cy++) begin
                for (int cx = x0; cx <= x1; cx++) begin
                    if ((cx - x) * (cx - x) + (cy - y) * (cy - y) <= r * r) begin
                        exp_addr.push_back(cy * GW + cx);
                        exp_cyc.push_back(2 + idx);
                    end
                    idx++;
                end
            end
        end
        done_k = 2 + idx;

        @(posedge clk); #1;
        start = 1'b1;
        bx = 8'(x); by = 8'(y); br = 8'(r); bt = 2'(t);
        gnt = (gmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        finished = 1'b0; holds = 0;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0;

        for (int k = 0; k < 40000 && !finished; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start = (k == restart_at);
                bx = 8'($urandom_range(0, 255));
                by = 8'($urandom_range(0, 255));
                br = 8'($urandom_range(0, 255));
                bt = 2'($urandom_range(0, 3));
                rst = (k == reset_at);
                case (gmode)
                    0: gnt = 1'b1;
                    1: gnt = 1'($urandom_range(0, 1));
                    default: begin
                        gnt = !(req && holds < 3);
                        if (req && holds < 3) holds++;
                    end
                endcase
            end
            @(negedge clk);
            if (reset_at >= 0 && k > reset_at) begin
                chk("reset_req", req, 0);
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                if (k >= reset_at + 4) finished = 1'b1;
            end else begin
                if (k == 0) chk("busy_before_start", busy, 0);
                if (gmode == 0 && k > 0) begin
                    chk("busy", busy, k < done_k);
                    chk("done", done, k == done_k);
                    chk("req_timing", req, exp_cyc.size() > 0 && exp_cyc[0] == k);
                end else if (k > 0 && !done) begin
                    chk("busy_hold", busy, 1);
                end
                if (prev_req && !prev_gnt) begin
                    chk("req_hold", req, 1);
                    chk("addr_hold", addr, prev_addr);
                end
                if (req && gnt) begin
                    if (exp_addr.size() == 0) begin
                        chk("extra_write", 1, 0);
                    end else begin
                        chk("addr", addr, exp_addr.pop_front());
                        chk("data", data, t);
                        void'(exp_cyc.pop_front());
                    end
                end
                if (done) begin
                    chk("writes_left", exp_addr.size(), 0);
                    chk("busy_at_done", busy, 0);
                    finished = 1'b1;
                end
                prev_req = req; prev_gnt = gnt; prev_addr = addr;
            end
        end
        if (!finished) chk("timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; gnt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gnt = 1'b0;
        bx = '0; by = '0; br = '0; bt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_stroke(10, 5, 0, 1, 0, -1, -1);
        run_stroke(10, 10, 1, 2, 0, -1, -1);
        run_stroke(0, 0, 2, 3, 0, -1, -1);
        run_stroke(10, 10, 1, 1, 2, -1, -1);
        run_stroke(10, 10, 1, 3, 0, 2, -1);
        run_stroke(200, 5, 3, 1, 0, -1, -1);
        run_stroke(5, 130, 3, 1, 0, -1, -1);
        run_stroke(159, 119, 3, 2, 0, -1, -1);
        run_stroke(20, 20, 4, 1, 0, -1, 5);
        run_stroke(30, 40, 2, 2, 0, -1, -1);
        run_stroke(80, 60, 70, 1, 1, -1, -1);
        for (int i = 0; i < 12; i++) begin
            run_stroke(int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
                       int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
